// File: rtl/y86_pkg.sv
// y86_pkg
// Shared constants for the Y86-64 execute-stage controller: instruction
// codes, ALU operation encodings, jXX/cmovXX condition function codes,
// the "no register" ID and bit positions inside the {ZF,SF,OF} CC vector.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // ALU control encodings; OPq ifun 0..3 maps directly onto these
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    // Condition function codes for jXX / cmovXX
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    // Bit positions inside cc = {ZF, SF, OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_cond_eval.sv
// y86_cond_eval
// Combinational evaluation of a jXX/cmovXX condition against the CC register.
// Ports:
//   ifun  in  4  condition function code
//   cc    in  3  {ZF,SF,OF}
//   cnd   out 1  condition outcome (0 for undefined codes above 6)
module y86_cond_eval (
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cnd
);
    import y86_pkg::*;

    logic zf;
    logic sf;
    logic of;
    logic lt;

    assign zf = cc[CC_ZF];
    assign sf = cc[CC_SF];
    assign of = cc[CC_OF];
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_exec_ctrl.sv
// y86_exec_ctrl
// Execute-stage controller for the Y86-64 pipeline. Decodes icode/ifun into
// the shared ALU's control and operand selects, owns the {ZF,SF,OF} condition
// code register, evaluates jXX/cmovXX conditions and registers the result in
// a single-entry valid/ready output register toward the memory stage.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             handshake from the decode stage
//   in_icode, in_ifun             instruction and function codes
//   in_valA, in_valB, in_valC     operands and immediate
//   in_dstE                       ALU-result destination register
//   alu_ctrl, alu_a, alu_b        combinational drive to the shared ALU
//   alu_result                    ALU output (gated buses ORed outside)
//   cc_block                      suppress CC update (later-stage exception)
//   out_valid/out_ready           handshake toward the memory stage
//   out_valE, out_dstE, out_cnd   registered result, destination, condition
//   cc_out                        current {ZF,SF,OF}
module y86_exec_ctrl #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_valA,
    input  logic [W-1:0] in_valB,
    input  logic [W-1:0] in_valC,
    input  logic [3:0]   in_dstE,
    output logic [1:0]   alu_ctrl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    input  logic         cc_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_valE,
    output logic [3:0]   out_dstE,
    output logic         out_cnd,
    output logic [2:0]   cc_out
);
    import y86_pkg::*;

    localparam logic [W-1:0] STACK_STEP = W'(8);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_vale_q, out_vale_d;
    logic [3:0]   out_dste_q, out_dste_d;
    logic         out_cnd_q, out_cnd_d;
    logic [2:0]   cc_q, cc_d;

    logic         accept;
    logic         op_valid;
    logic         opq_ok;
    logic         cond_raw;
    logic         cnd_sel;
    logic         new_zf;
    logic         new_sf;
    logic         new_of;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign opq_ok   = (in_icode == IOPQ) && (in_ifun <= 4'd3);

    // Operand / ALU op selection. op_valid marks icodes that produce a result;
    // everything else drives 0 + 0 and the registered result is forced to 0.
    always_comb begin
        alu_ctrl = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        op_valid = 1'b1;
        case (in_icode)
            IRRMOVQ: alu_a = in_valA;
            IIRMOVQ: alu_a = in_valC;
            IRMMOVQ, IMRMOVQ: begin
                alu_a = in_valB;
                alu_b = in_valC;
            end
            IOPQ: begin
                if (opq_ok) begin
                    alu_ctrl = in_ifun[1:0];
                    alu_a    = in_valB;
                    alu_b    = in_valA;
                end else begin
                    op_valid = 1'b0;
                end
            end
            ICALL, IPUSHQ: begin
                alu_ctrl = ALU_SUB;
                alu_a    = in_valB;
                alu_b    = STACK_STEP;
            end
            IRET, IPOPQ: begin
                alu_a = in_valB;
                alu_b = STACK_STEP;
            end
            default: op_valid = 1'b0;
        endcase
    end

    // Flags computed from the ALU result for the current selection
    assign new_zf = (alu_result == '0);
    assign new_sf = alu_result[W-1];

    always_comb begin
        new_of = 1'b0;
        case (alu_ctrl)
            ALU_ADD: new_of = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            ALU_SUB: new_of = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            default: new_of = 1'b0;
        endcase
    end

    // Conditions look at the CC register as it stands before this instruction
    y86_cond_eval u_cond_eval (
        .ifun (in_ifun),
        .cc   (cc_q),
        .cnd  (cond_raw)
    );

    assign cnd_sel = ((in_icode == IRRMOVQ) || (in_icode == IJXX)) ? cond_raw : 1'b1;

    always_comb begin
        out_valid_d = out_valid_q;
        out_vale_d  = out_vale_q;
        out_dste_d  = out_dste_q;
        out_cnd_d   = out_cnd_q;
        cc_d        = cc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_vale_d  = op_valid ? alu_result : '0;
            out_cnd_d   = cnd_sel;
            // A cmov whose condition fails writes nowhere
            out_dste_d  = ((in_icode == IRRMOVQ) && !cnd_sel) ? RNONE : in_dstE;
            if (opq_ok && !cc_block) begin
                cc_d = {new_zf, new_sf, new_of};
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_vale_q  <= '0;
            out_dste_q  <= RNONE;
            out_cnd_q   <= 1'b0;
            cc_q        <= CC_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            out_vale_q  <= out_vale_d;
            out_dste_q  <= out_dste_d;
            out_cnd_q   <= out_cnd_d;
            cc_q        <= cc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_valE  = out_vale_q;
    assign out_dstE  = out_dste_q;
    assign out_cnd   = out_cnd_q;
    assign cc_out    = cc_q;

endmodule

// File: tb/tb_y86_exec_ctrl.sv
module tb_y86_exec_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic [3:0]  in_ifun;
    logic [63:0] in_valA;
    logic [63:0] in_valB;
    logic [63:0] in_valC;
    logic [3:0]  in_dstE;
    logic [1:0]  alu_ctrl;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_result;
    logic        cc_block;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_valE;
    logic [3:0]  out_dstE;
    logic        out_cnd;
    logic [2:0]  cc_out;

    int tests;
    int fails;

    y86_exec_ctrl #(.W(64), .RNONE(4'hF)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_icode   (in_icode),
        .in_ifun    (in_ifun),
        .in_valA    (in_valA),
        .in_valB    (in_valB),
        .in_valC    (in_valC),
        .in_dstE    (in_dstE),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .cc_block   (cc_block),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_valE   (out_valE),
        .out_dstE   (out_dstE),
        .out_cnd    (out_cnd),
        .cc_out     (cc_out)
    );

    // Stand-in for the external shared ALU
    always_comb begin
        case (alu_ctrl)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] va;
        logic [63:0] vb;
        logic [63:0] vc;
        logic [3:0]  dst;
        logic        blk;
        logic [1:0]  e_ctrl;
        logic [63:0] e_a;
        logic [63:0] e_b;
        logic [63:0] e_vale;
        logic [3:0]  e_dst;
        logic        e_cnd;
        logic [2:0]  e_cc;
    } vec_t;

    localparam int NV = 32;
    vec_t v[NV];

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic vec_t mk(
        input logic [3:0] icode, input logic [3:0] ifun,
        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
        input logic [3:0] dst, input logic blk,
        input logic [1:0] e_ctrl, input logic [63:0] e_a, input logic [63:0] e_b,
        input logic [63:0] e_vale, input logic [3:0] e_dst, input logic e_cnd,
        input logic [2:0] e_cc);
        vec_t r;
        r.icode = icode; r.ifun = ifun; r.va = va; r.vb = vb; r.vc = vc;
        r.dst = dst; r.blk = blk; r.e_ctrl = e_ctrl; r.e_a = e_a; r.e_b = e_b;
        r.e_vale = e_vale; r.e_dst = e_dst; r.e_cnd = e_cnd; r.e_cc = e_cc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] vc, input logic [3:0] dst,
                         input logic blk);
        in_icode = icode; in_ifun = ifun; in_valA = va; in_valB = vb;
        in_valC = vc; in_dstE = dst; cc_block = blk;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        //          ic    fn    valA    valB     valC    dst   blk ctrl  alu_a   alu_b   valE                   dst  cnd cc
        v[0]  = mk(4'h6, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2, 0, 2'd1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'h2, 1, 3'b010);
        v[1]  = mk(4'h6, 4'h0, MAXP, 64'd1, 64'h0, 4'h4, 0, 2'd0, 64'd1, MAXP, MINN, 4'h4, 1, 3'b011);
        v[2]  = mk(4'h7, 4'h2, 64'h11, 64'h22, 64'h33, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 0, 3'b011);
        v[3]  = mk(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 0, 3'b011);
        v[4]  = mk(4'h6, 4'h1, 64'd7, 64'd7, 64'h0, 4'h5, 0, 2'd1, 64'd7, 64'd7, 64'd0, 4'h5, 1, 3'b100);
        v[5]  = mk(4'h2, 4'h1, 64'h1234, 64'h99, 64'h77, 4'h3, 0, 2'd0, 64'h1234, 64'd0, 64'h1234, 4'h3, 1, 3'b100);
        v[6]  = mk(4'h2, 4'h2, 64'h55, 64'h0, 64'h0, 4'h3, 0, 2'd0, 64'h55, 64'd0, 64'h55, 4'hF, 0, 3'b100);
        v[7]  = mk(4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 0, 2'd1, 64'h100, 64'd8, 64'hF8, 4'h4, 1, 3'b100);
        v[8]  = mk(4'hB, 4'h0, 64'h0, 64'hF8, 64'h0, 4'h4, 0, 2'd0, 64'hF8, 64'd8, 64'h100, 4'h4, 1, 3'b100);
        v[9]  = mk(4'h3, 4'h0, 64'h5, 64'h6, 64'hABCD, 4'h6, 0, 2'd0, 64'hABCD, 64'd0, 64'hABCD, 4'h6, 1, 3'b100);
        v[10] = mk(4'h5, 4'h0, 64'h0, 64'h1000, 64'h20, 4'hF, 0, 2'd0, 64'h1000, 64'h20, 64'h1020, 4'hF, 1, 3'b100);
        v[11] = mk(4'h6, 4'h2, 64'hFF0, 64'h0FF, 64'h0, 4'h1, 0, 2'd2, 64'h0FF, 64'hFF0, 64'h0F0, 4'h1, 1, 3'b000);
        v[12] = mk(4'h6, 4'h3, ONES, 64'h0, 64'h0, 4'h1, 0, 2'd3, 64'd0, ONES, ONES, 4'h1, 1, 3'b010);
        v[13] = mk(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 0, 3'b010);
        v[14] = mk(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 0, 3'b010);
        v[15] = mk(4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 1, 3'b010);
        v[16] = mk(4'h7, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 1, 3'b010);
        v[17] = mk(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 0, 3'b010);
        v[18] = mk(4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 0, 3'b010);
        v[19] = mk(4'h6, 4'h5, 64'd3, 64'd4, 64'h0, 4'h2, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'h2, 1, 3'b010);
        v[20] = mk(4'h6, 4'h0, 64'd2, 64'd3, 64'h0, 4'h2, 1, 2'd0, 64'd3, 64'd2, 64'd5, 4'h2, 1, 3'b010);
        v[21] = mk(4'h6, 4'h0, MINN, MINN, 64'h0, 4'h2, 0, 2'd0, MINN, MINN, 64'd0, 4'h2, 1, 3'b101);
        v[22] = mk(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 1, 3'b101);
        v[23] = mk(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 0, 3'b101);
        v[24] = mk(4'h2, 4'h6, 64'h77, 64'h0, 64'h0, 4'h3, 0, 2'd0, 64'h77, 64'd0, 64'h77, 4'hF, 0, 3'b101);
        v[25] = mk(4'h6, 4'h1, 64'd1, MINN, 64'h0, 4'h2, 0, 2'd1, MINN, 64'd1, MAXP, 4'h2, 1, 3'b001);
        v[26] = mk(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 1, 3'b001);
        v[27] = mk(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 0, 3'b001);
        v[28] = mk(4'h0, 4'h0, 64'h5, 64'h6, 64'h7, 4'hF, 0, 2'd0, 64'd0, 64'd0, 64'd0, 4'hF, 1, 3'b001);
        v[29] = mk(4'h4, 4'h0, 64'h999, 64'h200, 64'h8, 4'hF, 0, 2'd0, 64'h200, 64'h8, 64'h208, 4'hF, 1, 3'b001);
        v[30] = mk(4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 0, 2'd1, 64'h200, 64'd8, 64'h1F8, 4'h4, 1, 3'b001);
        v[31] = mk(4'h9, 4'h0, 64'h0, 64'h1F8, 64'h0, 4'h4, 0, 2'd0, 64'h1F8, 64'd8, 64'h200, 4'h4, 1, 3'b001);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_valE", out_valE, 64'd0);
        chk("rst out_dstE", out_dstE, 4'hF);
        chk("rst out_cnd", out_cnd, 1'b0);
        chk("rst cc_out", cc_out, 3'b100);
        chk("rst in_ready", in_ready, 1'b1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(v[i].icode, v[i].ifun, v[i].va, v[i].vb, v[i].vc, v[i].dst, v[i].blk);
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d alu_ctrl", i), alu_ctrl, v[i].e_ctrl);
            chk($sformatf("v%0d alu_a", i), alu_a, v[i].e_a);
            chk($sformatf("v%0d alu_b", i), alu_b, v[i].e_b);
            chk($sformatf("v%0d in_ready", i), in_ready, 1'b1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i), out_valid, 1'b1);
            chk($sformatf("v%0d out_valE", i), out_valE, v[i].e_vale);
            chk($sformatf("v%0d out_dstE", i), out_dstE, v[i].e_dst);
            chk($sformatf("v%0d out_cnd", i), out_cnd, v[i].e_cnd);
            chk($sformatf("v%0d cc_out", i), cc_out, v[i].e_cc);
        end

        // Idle cycle with out_ready high drains the output register
        @(posedge clk);
        #1;
        chk("drain out_valid", out_valid, 1'b0);

        // Stall: addq 1+1 parked in the output, subq 9-9 waits behind it
        @(negedge clk);
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'h0, 4'h3, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("stall pre valE", out_valE, 64'd2);
        chk("stall pre cc", cc_out, 3'b000);
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'h6, 4'h1, 64'd9, 64'd9, 64'h0, 4'h5, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d in_ready", c), in_ready, 1'b0);
            chk($sformatf("stall%0d out_valid", c), out_valid, 1'b1);
            chk($sformatf("stall%0d out_valE", c), out_valE, 64'd2);
            chk($sformatf("stall%0d out_dstE", c), out_dstE, 4'h3);
            chk($sformatf("stall%0d cc_out", c), cc_out, 3'b000);
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", in_ready, 1'b1);
        chk("release cc before edge", cc_out, 3'b000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("release out_valE", out_valE, 64'd0);
        chk("release out_dstE", out_dstE, 4'h5);
        chk("release cc_out", cc_out, 3'b100);
        @(posedge clk);
        #1;
        chk("release drain", out_valid, 1'b0);

        // Reset while an entry is stalled in the output register
        @(negedge clk);
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'h0, 4'h3, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("prerst cc_out", cc_out, 3'b000);
        @(negedge clk);
        chk("prerst out_valid", out_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst out_valid", out_valid, 1'b0);
        chk("midrst cc_out", cc_out, 3'b100);
        chk("midrst out_dstE", out_dstE, 4'hF);
        chk("midrst out_valE", out_valE, 64'd0);
        out_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
